// File: rtl/center_buf_rd_ctrl_pkg.sv
// Shared output-path definitions for the center buffer read controller.
// Holds the FSM state encoding and the skid FIFO depth.
package center_buf_rd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CW    = 2;

endpackage

// File: rtl/center_buf_rd_ctrl_if.sv
// Command, buffer-read and output-stream bundle for the read controller.
// slave = controller side, master = environment side.
interface center_buf_rd_ctrl_if #(
    parameter int DATA_WIDTH = 256,
    parameter int log2_DEPTH = 5
);
    logic                  cmd_vld;
    logic                  cmd_rdy;
    logic [log2_DEPTH-1:0] cmd_base_addr;
    logic [log2_DEPTH:0]   cmd_len;
    logic                  buf_rd_en;
    logic [log2_DEPTH-1:0] buf_rd_addr;
    logic                  buf_rd_dat_vld;
    logic [DATA_WIDTH-1:0] buf_rd_dat;
    logic                  m_vld;
    logic                  m_rdy;
    logic [DATA_WIDTH-1:0] m_dat;
    logic                  m_last;
    logic                  busy;
    logic                  done;

    modport slave (
        input  cmd_vld, cmd_base_addr, cmd_len,
        input  buf_rd_dat_vld, buf_rd_dat, m_rdy,
        output cmd_rdy, buf_rd_en, buf_rd_addr,
        output m_vld, m_dat, m_last, busy, done
    );

    modport master (
        output cmd_vld, cmd_base_addr, cmd_len,
        output buf_rd_dat_vld, buf_rd_dat, m_rdy,
        input  cmd_rdy, buf_rd_en, buf_rd_addr,
        input  m_vld, m_dat, m_last, busy, done
    );

endinterface

// File: rtl/center_buf_rd_ctrl_out_skid_fifo.sv
// Two-entry skid FIFO between buffer read data and the output stream.
// Head entry r_d0 drives the stream directly.
module out_skid_fifo
    import center_buf_rd_ctrl_pkg::*;
#(
    parameter int W = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [W-1:0]       i_din,
    input  logic               i_pop,
    output logic [W-1:0]       o_dout,
    output logic               o_vld,
    output logic [FIFO_CW-1:0] o_count
);

    logic [W-1:0]       r_d0;
    logic [W-1:0]       r_d1;
    logic [FIFO_CW-1:0] r_cnt;

    // storage shift and occupancy; push into a full FIFO without pop is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_cnt <= '0;
        end else begin
            case (r_cnt)
                2'd0: begin
                    if (i_push) begin
                        r_d0  <= i_din;
                        r_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && i_pop) begin
                        r_d0 <= i_din;
                    end else if (i_push) begin
                        r_d1  <= i_din;
                        r_cnt <= 2'd2;
                    end else if (i_pop) begin
                        r_cnt <= 2'd0;
                    end
                end
                2'd2: begin
                    if (i_pop) begin
                        r_d0 <= r_d1;
                        if (i_push) r_d1 <= i_din;
                        else        r_cnt <= 2'd1;
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign o_dout  = r_d0;
    assign o_vld   = (r_cnt != '0);
    assign o_count = r_cnt;

endmodule

// File: rtl/center_buf_rd_ctrl.sv
// Center buffer read controller: turns (base, len) commands into buffer
// reads and a credit-limited, back-pressured output stream.
module center_buf_rd_ctrl
    import center_buf_rd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 32,
    parameter int log2_DEPTH = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    center_buf_rd_ctrl_if.slave  bus
);

    rd_state_e             r_state;
    rd_state_e             w_state_nxt;
    logic [log2_DEPTH-1:0] r_addr;
    logic [log2_DEPTH:0]   r_rem;
    logic [log2_DEPTH:0]   r_len;
    logic [log2_DEPTH:0]   r_beat;
    logic [1:0]            r_infl;
    logic                  r_zdone;

    logic                  w_cmd_rdy;
    logic                  w_accept;
    logic                  w_rd_en;
    logic                  w_done_fsm;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_m_vld;
    logic                  w_m_last;
    logic [DATA_WIDTH-1:0] w_m_dat;
    logic [FIFO_CW-1:0]    w_cnt;
    logic [2:0]            w_occ;
    logic                  w_credit;
    logic [log2_DEPTH-1:0] w_addr_nxt;

    assign w_accept = bus.cmd_vld && w_cmd_rdy;
    assign w_push   = bus.buf_rd_dat_vld && (r_infl != 2'd0);
    assign w_pop    = w_m_vld && bus.m_rdy;
    assign w_occ    = {1'b0, w_cnt} + {1'b0, r_infl};
    assign w_credit = (w_occ < 3'(FIFO_DEPTH)) ||
                      ((w_occ == 3'(FIFO_DEPTH)) && w_pop);
    assign w_m_last = w_m_vld && (r_state != ST_IDLE) &&
                      (r_beat == r_len - 1'b1);
    assign w_addr_nxt = (r_addr == log2_DEPTH'(DEPTH - 1)) ?
                        '0 : r_addr + 1'b1;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // next state, read strobe and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_rdy   = 1'b0;
        w_rd_en     = 1'b0;
        w_done_fsm  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cmd_rdy = 1'b1;
                if (bus.cmd_vld && (bus.cmd_len != '0))
                    w_state_nxt = ST_READ;
            end
            ST_READ: begin
                w_rd_en = w_credit;
                if (w_credit && (r_rem == 1))
                    w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop && w_m_last) begin
                    w_done_fsm  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // command latch, address walk and beat/in-flight accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_rem   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_infl  <= '0;
            r_zdone <= 1'b0;
        end else begin
            r_zdone <= w_accept && (bus.cmd_len == '0);
            if (w_pop) r_beat <= r_beat + 1'b1;
            if (w_accept && (bus.cmd_len != '0)) begin
                r_addr <= bus.cmd_base_addr;
                r_rem  <= bus.cmd_len;
                r_len  <= bus.cmd_len;
                r_beat <= '0;
            end else if (w_rd_en) begin
                r_addr <= w_addr_nxt;
                r_rem  <= r_rem - 1'b1;
            end
            case ({w_rd_en, w_push})
                2'b10:   r_infl <= r_infl + 1'b1;
                2'b01:   r_infl <= r_infl - 1'b1;
                default: r_infl <= r_infl;
            endcase
        end
    end

    out_skid_fifo #(.W(DATA_WIDTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (bus.buf_rd_dat),
        .i_pop   (w_pop),
        .o_dout  (w_m_dat),
        .o_vld   (w_m_vld),
        .o_count (w_cnt)
    );

    assign bus.cmd_rdy     = w_cmd_rdy;
    assign bus.buf_rd_en   = w_rd_en;
    assign bus.buf_rd_addr = r_addr;
    assign bus.m_vld       = w_m_vld;
    assign bus.m_dat       = w_m_dat;
    assign bus.m_last      = w_m_last;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = r_zdone || w_done_fsm;

endmodule
